fixedpoint_block_accum: RTL and testbench

FIXEDPOINT_BLOCK_ACCUM -- requirements
Module: fixedpoint_block_accum

---
 rtl/fixedpoint_block_accum_pkg.sv | 19 +
 rtl/comb_FixedPointZoom.sv | 44 ++++
 rtl/fixedpoint_block_accum.sv | 119 +++++++++++
 tb/tb_fixedpoint_block_accum.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixedpoint_block_accum_pkg.sv
// Shared fixed-point helpers: FSM encoding and width functions for the block accumulator.
package fixedpoint_block_accum_pkg;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Accumulator width that can hold LEN full-scale samples without overflow.
    function automatic int acc_width(input int wii, input int wif, input int len);
        return wii + wif + $clog2(len);
    endfunction

    // Counter width able to represent 0..LEN.
    function automatic int count_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// Combinational fixed-point resize WII.WIF -> WOI.WOF with floor truncation and saturate/wrap.
module comb_FixedPointZoom #(
    parameter int WII  = 12,
    parameter int WIF  = 10,
    parameter int WOI  = 12,
    parameter int WOF  = 10,
    parameter int ROOF = 1
) (
    input  logic signed [WII+WIF-1:0] in_data,
    output logic signed [WOI+WOF-1:0] out_data,
    output logic                      overflow
);

    localparam int WMID = WII + WOF;
    localparam int OW   = WOI + WOF;

    // Value re-scaled to WOF fraction bits but still carrying all WII integer bits.
    logic signed [WMID-1:0] mid;

    generate
        if (WOF >= WIF) begin : g_frac_ext
            assign mid = WMID'(in_data) <<< (WOF - WIF);
        end else begin : g_frac_cut
            // Arithmetic shift drops fraction bits toward negative infinity.
            assign mid = WMID'(in_data >>> (WIF - WOF));
        end

        if (WOI >= WII) begin : g_int_ext
            assign out_data = OW'(mid);
            assign overflow = 1'b0;
        end else begin : g_int_cut
            localparam int HW = WMID - OW + 1;
            localparam logic signed [OW-1:0] MAX_CODE = {1'b0, {(OW-1){1'b1}}};
            localparam logic signed [OW-1:0] MIN_CODE = {1'b1, {(OW-1){1'b0}}};
            logic [HW-1:0] hi;
            // Value fits only if every dropped bit equals the new sign bit.
            assign hi       = mid[WMID-1:OW-1];
            assign overflow = !((&hi) || !(|hi));
            assign out_data = (overflow && ROOF != 0) ? (mid[WMID-1] ? MIN_CODE : MAX_CODE)
                                                      : mid[OW-1:0];
        end
    endgenerate

endmodule

// File: rtl/fixedpoint_block_accum.sv
// Block accumulator: sums up to LEN fixed-point samples, then presents one resized result.
module fixedpoint_block_accum
    import fixedpoint_block_accum_pkg::*;
#(
    parameter int WII  = 10,
    parameter int WIF  = 10,
    parameter int WOI  = 12,
    parameter int WOF  = 10,
    parameter int LEN  = 4,
    parameter int ROOF = 1
) (
    input  logic                          rstn,
    input  logic                          clk,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic signed [WII+WIF-1:0]     i_data,
    input  logic                          i_upflow,
    input  logic                          i_downflow,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic signed [WOI+WOF-1:0]     o_sum,
    output logic [count_width(LEN)-1:0]   o_count,
    output logic                          o_upflow,
    output logic                          o_downflow
);

    localparam int AW = acc_width(WII, WIF, LEN);
    localparam int CW = count_width(LEN);
    localparam int OW = WOI + WOF;

    state_t               state, state_nxt;
    logic                 armed;
    logic signed [AW-1:0] acc, acc_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 sticky_up, sticky_dn;
    logic                 accept, close;
    logic signed [OW-1:0] zoom_sum;
    logic                 zoom_ovf;

    assign accept  = i_valid && i_ready;
    assign acc_nxt = acc + AW'(i_data);
    assign cnt_nxt = cnt + CW'(1);
    assign close   = accept && (i_last || cnt == CW'(LEN - 1));

    comb_FixedPointZoom #(
        .WII  (AW - WIF),
        .WIF  (WIF),
        .WOI  (WOI),
        .WOF  (WOF),
        .ROOF (ROOF)
    ) u_zoom (
        .in_data  (acc_nxt),
        .out_data (zoom_sum),
        .overflow (zoom_ovf)
    );

    // State register plus the one-cycle arming that keeps i_ready low until after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_ACC;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            ST_ACC: begin
                i_ready = armed;
                if (close) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // Accumulate accepted samples; on the closing sample capture the result and clear the block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc        <= '0;
            cnt        <= '0;
            sticky_up  <= 1'b0;
            sticky_dn  <= 1'b0;
            o_sum      <= '0;
            o_count    <= '0;
            o_upflow   <= 1'b0;
            o_downflow <= 1'b0;
        end else if (accept) begin
            if (close) begin
                acc        <= '0;
                cnt        <= '0;
                sticky_up  <= 1'b0;
                sticky_dn  <= 1'b0;
                o_sum      <= zoom_sum;
                o_count    <= cnt_nxt;
                o_upflow   <= sticky_up | i_upflow | zoom_ovf;
                o_downflow <= sticky_dn | i_downflow;
            end else begin
                acc       <= acc_nxt;
                cnt       <= cnt_nxt;
                sticky_up <= sticky_up | i_upflow;
                sticky_dn <= sticky_dn | i_downflow;
            end
        end
    end

endmodule

// File: tb/tb_fixedpoint_block_accum.sv
// Self-checking bench: two configurations (exact-fit and saturating/truncating) vs. an arithmetic model.
module tb_fixedpoint_block_accum;

    localparam int WOI  = 12;
    localparam int WOF  = 10;
    localparam int ROOF = 1;
    localparam int WII0 = 10, WIF0 = 10;
    localparam int WII1 = 11, WIF1 = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic [1:0]       iv, iup, idn, ilast, ordy;
    logic [1:0][22:0] idat;
    wire  [1:0]       irdy, ov, oup, odn;
    wire  [1:0][21:0] osum;
    wire  [1:0][2:0]  ocnt;

    int n_checks = 0;
    int n_fail   = 0;

    longint blk_dat[$];
    bit     blk_up[$];
    bit     blk_dn[$];

    always #5 clk = ~clk;

    fixedpoint_block_accum #(
        .WII(WII0), .WIF(WIF0), .WOI(WOI), .WOF(WOF), .LEN(4), .ROOF(ROOF)
    ) dut0 (
        .rstn(rstn), .clk(clk), .i_valid(iv[0]), .i_ready(irdy[0]), .i_data(idat[0][19:0]),
        .i_upflow(iup[0]), .i_downflow(idn[0]), .i_last(ilast[0]), .o_valid(ov[0]),
        .o_ready(ordy[0]), .o_sum(osum[0]), .o_count(ocnt[0]), .o_upflow(oup[0]),
        .o_downflow(odn[0])
    );

    fixedpoint_block_accum #(
        .WII(WII1), .WIF(WIF1), .WOI(WOI), .WOF(WOF), .LEN(4), .ROOF(ROOF)
    ) dut1 (
        .rstn(rstn), .clk(clk), .i_valid(iv[1]), .i_ready(irdy[1]), .i_data(idat[1]),
        .i_upflow(iup[1]), .i_downflow(idn[1]), .i_last(ilast[1]), .o_valid(ov[1]),
        .o_ready(ordy[1]), .o_sum(osum[1]), .o_count(ocnt[1]), .o_upflow(oup[1]),
        .o_downflow(odn[1])
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Exact block sum re-scaled to WOF fraction bits (floor), then clamped or wrapped to WOI.WOF.
    function automatic longint model_resize(input longint s, input int wif, output bit ovf);
        longint v, d, lim;
        if (WOF >= wif) begin
            v = s * (longint'(1) << (WOF - wif));
        end else begin
            d = longint'(1) << (wif - WOF);
            v = s / d;
            if (s < 0 && (s % d) != 0) v = v - 1;
        end
        lim = longint'(1) << (WOI + WOF - 1);
        ovf = (v > lim - 1) || (v < -lim);
        if (ovf) begin
            if (ROOF != 0) v = (v > 0) ? lim - 1 : -lim;
            else begin
                v = ((v % (2 * lim)) + 2 * lim) % (2 * lim);
                if (v >= lim) v = v - 2 * lim;
            end
        end
        return v;
    endfunction

    task automatic junk(input int sel, input logic valid);
        iv[sel]    = valid;
        idat[sel]  = 23'($urandom);
        iup[sel]   = 1'b1;
        idn[sel]   = 1'b1;
        ilast[sel] = 1'b1;
    endtask

    task automatic idle(input int sel);
        iv[sel]    = 1'b0;
        iup[sel]   = 1'b0;
        idn[sel]   = 1'b0;
        ilast[sel] = 1'b0;
    endtask

    // Drive the queued samples into one DUT, check the result, optionally hold and release it.
    task automatic send_block(input int sel, input bit last, input int stall,
                              input bit gaps, input bit rel);
        int                n, wif, waits;
        longint            acc, exp_sum;
        bit                eu, ed, ovf;
        logic signed [21:0] s;
        n   = blk_dat.size();
        wif = (sel == 0) ? WIF0 : WIF1;
        acc = 0;
        eu  = 1'b0;
        ed  = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                junk(sel, 1'b0);
                @(negedge clk);
            end
            iv[sel]    = 1'b1;
            idat[sel]  = 23'(blk_dat[k]);
            iup[sel]   = blk_up[k];
            idn[sel]   = blk_dn[k];
            ilast[sel] = last && (k == n - 1);
            waits = 0;
            while (irdy[sel] !== 1'b1 && waits < 16) begin
                @(negedge clk);
                waits++;
            end
            if (waits >= 16) check("ready_timeout", 0, 1);
            @(negedge clk);
            acc += blk_dat[k];
            eu  |= blk_up[k];
            ed  |= blk_dn[k];
            if (k < n - 1) check("mid_block_valid", ov[sel], 0);
        end
        exp_sum = model_resize(acc, wif, ovf);
        s = osum[sel];
        check("o_valid", ov[sel], 1);
        check("i_ready_in_out", irdy[sel], 0);
        check("o_sum", s, exp_sum);
        check("o_count", ocnt[sel], n);
        check("o_upflow", oup[sel], eu | ovf);
        check("o_downflow", odn[sel], ed);
        if (!rel) begin
            idle(sel);
            return;
        end
        junk(sel, 1'b1);
        repeat (stall) begin
            @(negedge clk);
            s = osum[sel];
            check("hold_valid", ov[sel], 1);
            check("hold_ready", irdy[sel], 0);
            check("hold_sum", s, exp_sum);
            check("hold_count", ocnt[sel], n);
        end
        ordy[sel] = 1'b1;
        @(negedge clk);
        ordy[sel] = 1'b0;
        idle(sel);
        check("post_hs_valid", ov[sel], 0);
        check("post_hs_ready", irdy[sel], 1);
    endtask

    task automatic do_reset();
        logic signed [21:0] s;
        @(negedge clk);
        rstn = 1'b0;
        idle(0);
        idle(1);
        ordy = '0;
        @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            s = osum[sel];
            check("rst_o_valid", ov[sel], 0);
            check("rst_i_ready", irdy[sel], 0);
            check("rst_o_sum", s, 0);
            check("rst_o_count", ocnt[sel], 0);
            check("rst_o_upflow", oup[sel], 0);
            check("rst_o_downflow", odn[sel], 0);
        end
        rstn = 1'b1;
        #1;
        check("i_ready_before_edge", irdy, 2'b00);
        @(negedge clk);
        check("i_ready_after_edge", irdy, 2'b11);
    endtask

    task automatic fill(input longint v, input int n);
        blk_dat.delete();
        blk_up.delete();
        blk_dn.delete();
        for (int k = 0; k < n; k++) begin
            blk_dat.push_back(v);
            blk_up.push_back(1'b0);
            blk_dn.push_back(1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     sel, n, iw, stall;
        bit     last;
        longint raw;
        iv = '0; iup = '0; idn = '0; ilast = '0; ordy = '0; idat = '0;
        rstn = 1'b0;
        do_reset();

        // Full block of four samples.
        blk_dat = '{1536, 2304, -768, 3072};
        blk_up  = '{0, 0, 0, 0};
        blk_dn  = '{0, 0, 0, 0};
        send_block(0, 1'b0, 1, 1'b0, 1'b1);

        // Early close after two samples.
        blk_dat = '{1024, 2048};
        blk_up  = '{0, 0};
        blk_dn  = '{0, 0};
        send_block(0, 1'b1, 0, 1'b0, 1'b1);

        // Saturation on the wider-input configuration: 4 x +600.0 and 4 x -600.0.
        fill(longint'(600) << WIF1, 4);
        send_block(1, 1'b0, 1, 1'b0, 1'b1);
        fill(-(longint'(600) << WIF1), 4);
        send_block(1, 1'b0, 1, 1'b0, 1'b1);

        // Most negative full-scale samples in the exact-fit configuration.
        fill(-(longint'(1) << 19), 4);
        send_block(0, 1'b0, 0, 1'b0, 1'b1);

        // Converter flags pass through, then clear for the next block.
        blk_dat = '{100, 200, 300, 400};
        blk_up  = '{0, 1, 0, 0};
        blk_dn  = '{0, 0, 1, 0};
        send_block(0, 1'b0, 0, 1'b0, 1'b1);
        blk_dat = '{1, 2, 3, 4};
        blk_up  = '{0, 0, 0, 0};
        blk_dn  = '{0, 0, 0, 0};
        send_block(0, 1'b0, 0, 1'b0, 1'b1);

        // Backpressure: result held for five cycles while junk is offered.
        blk_dat = '{-5000, 7000, 123, -1};
        send_block(0, 1'b0, 5, 1'b0, 1'b1);

        // Reset in mid-block discards the partial sum.
        iv[0] = 1'b1; idat[0] = 23'(1024); ilast[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        idle(0);
        do_reset();
        fill(1024, 4);
        send_block(0, 1'b0, 0, 1'b0, 1'b1);

        // Reset while a result is pending discards it.
        fill(777, 4);
        send_block(0, 1'b0, 0, 1'b0, 1'b0);
        do_reset();
        fill(-2048, 3);
        send_block(0, 1'b1, 0, 1'b0, 1'b1);

        // Randomized blocks on both configurations.
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 1);
            n   = $urandom_range(1, 4);
            iw  = (sel == 0) ? (WII0 + WIF0) : (WII1 + WIF1);
            blk_dat.delete();
            blk_up.delete();
            blk_dn.delete();
            for (int k = 0; k < n; k++) begin
                raw = longint'($urandom_range(0, (1 << iw) - 1)) - (longint'(1) << (iw - 1));
                blk_dat.push_back(raw);
                blk_up.push_back($urandom_range(0, 7) == 0);
                blk_dn.push_back($urandom_range(0, 7) == 0);
            end
            last  = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            send_block(sel, last, stall, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
